vector_fetch: RTL

VECTOR_FETCH -- requirements
Module: vector_fetch

---
 rtl/vector_fetch.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vector_fetch.sv
// vector_fetch: streams VECTOR_WIDTH-element vector pairs from two memories to a dot-product stage.
// Define VECTOR_FETCH_TIMEOUT_EN to add an 8-bit WAIT_RESULT watchdog that drives timeout_err.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for start; start with vec_count=0 goes to S_DONE
// S_READ      | one read enable per cycle, VECTOR_WIDTH cycles per vector
// S_DRAIN     | one cycle while the last read returns
// S_WAIT      | waiting for result_done from the dot-product stage
// S_DONE      | one-cycle done pulse, then back to S_IDLE
module vector_fetch #(
   parameter int DATA_WIDTH   = 8,
   parameter int VECTOR_WIDTH = 4,
   parameter int ADDR_WIDTH   = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] vec_count,
   output logic                  mem1_en,
   output logic                  mem2_en,
   output logic [ADDR_WIDTH-1:0] mem1_addr,
   output logic [ADDR_WIDTH-1:0] mem2_addr,
   input  logic [DATA_WIDTH-1:0] mem1_rdata,
   input  logic [DATA_WIDTH-1:0] mem2_rdata,
   output logic [DATA_WIDTH-1:0] mem1_output,
   output logic [DATA_WIDTH-1:0] mem2_output,
   output logic                  data_valid,
   input  logic                  result_done,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err
);
   localparam int EW = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
   localparam logic [EW-1:0]         E_LAST = EW'(VECTOR_WIDTH - 1);
   localparam logic [EW-1:0]         E_ONE  = EW'(1);
   localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] A_ZERO = '0;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WAIT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] vec_cnt_q, vec_cnt_d;
   logic [ADDR_WIDTH-1:0] vec_idx_q, vec_idx_d;
   logic [ADDR_WIDTH-1:0] vec_idx_inc;
   logic [EW-1:0]         elem_q, elem_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] out1_q, out1_d;
   logic [DATA_WIDTH-1:0] out2_q, out2_d;
   logic                  result_ack;
`ifdef VECTOR_FETCH_TIMEOUT_EN
   logic [7:0]            wd_q, wd_d;
   logic                  timeout_q, timeout_d;
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      vec_cnt_d   = vec_cnt_q;
      vec_idx_d   = vec_idx_q;
      elem_d      = elem_q;
      rd_pend_d   = (state_q == S_READ);
      valid_d     = rd_pend_q;
      out1_d      = rd_pend_q ? mem1_rdata : out1_q;
      out2_d      = rd_pend_q ? mem2_rdata : out2_q;
      vec_idx_inc = vec_idx_q + A_ONE;
      // A result_done landing with the final beat belongs to no finished vector yet.
      result_ack  = (state_q == S_WAIT) && result_done && !valid_q;
`ifdef VECTOR_FETCH_TIMEOUT_EN
      wd_d        = wd_q;
      timeout_d   = timeout_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
`ifdef VECTOR_FETCH_TIMEOUT_EN
               timeout_d = 1'b0;
`endif
               if (vec_count != A_ZERO) begin
                  addr_d    = base_addr;
                  vec_cnt_d = vec_count;
                  vec_idx_d = A_ZERO;
                  elem_d    = '0;
                  state_d   = S_READ;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_READ: begin
            addr_d = addr_q + A_ONE;
            if (elem_q == E_LAST) begin
               elem_d  = '0;
               state_d = S_DRAIN;
            end else begin
               elem_d = elem_q + E_ONE;
            end
         end
         S_DRAIN: begin
`ifdef VECTOR_FETCH_TIMEOUT_EN
            wd_d = 8'd0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (result_ack) begin
               vec_idx_d = vec_idx_inc;
               state_d   = (vec_idx_inc == vec_cnt_q) ? S_DONE : S_READ;
            end
`ifdef VECTOR_FETCH_TIMEOUT_EN
            else if (wd_q == 8'd254) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               wd_d = wd_q + 8'd1;
            end
`endif
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         vec_cnt_q <= '0;
         vec_idx_q <= '0;
         elem_q    <= '0;
         rd_pend_q <= 1'b0;
         valid_q   <= 1'b0;
         out1_q    <= '0;
         out2_q    <= '0;
`ifdef VECTOR_FETCH_TIMEOUT_EN
         wd_q      <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         vec_cnt_q <= vec_cnt_d;
         vec_idx_q <= vec_idx_d;
         elem_q    <= elem_d;
         rd_pend_q <= rd_pend_d;
         valid_q   <= valid_d;
         out1_q    <= out1_d;
         out2_q    <= out2_d;
`ifdef VECTOR_FETCH_TIMEOUT_EN
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign mem1_en     = (state_q == S_READ);
   assign mem2_en     = (state_q == S_READ);
   assign mem1_addr   = addr_q;
   assign mem2_addr   = addr_q;
   assign mem1_output = out1_q;
   assign mem2_output = out2_q;
   assign data_valid  = valid_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
`ifdef VECTOR_FETCH_TIMEOUT_EN
   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule
